uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single transmit path of uart_top among NUM_REQ independent byte sources.
- Round-robin arbitration with packet locking: a multi-byte packet marked by req_last is never interleaved with other requesters.
- Sequences the uart_top wr_en/wr_data/tx_busy handshake: one byte issued, then waits for tx_busy to rise and fall before the next grant.
- Sits between client logic (command responders, debug/status streams) and uart_top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after wr_en before flagging an error (1..15).

Ports:
- clk  input  1  system clock.
- rstb  input  1  reset; asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of its packet.
- req_ready  output  NUM_REQ  byte accepted this cycle when paired with req_valid.
- wr_en  output  1  one-cycle write strobe to uart_top.
- wr_data  output  8  byte to uart_top; held stable from the wr_en cycle until the FSM returns to IDLE.
- tx_busy  input  1  uart_top transmitter busy.
- owner  output  clog2(NUM_REQ)  index of the last granted requester.
- locked  output  1  a packet is in progress; only owner may be granted.
- timeout_err  output  1  sticky; tx_busy failed to rise within BUSY_TIMEOUT cycles of wr_en.

Behaviour:
- Reset values: wr_en=0, wr_data=0, req_ready=0, owner=0, locked=0, timeout_err=0, rr_ptr=0, state=IDLE, timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE, arbitration:
  - Candidate set: {owner} if locked, otherwise all i with req_valid[i].
  - Winner: first candidate scanning upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
  - req_ready is combinational and asserted only for the winner, only in IDLE, only when tx_busy=0.
  - A transfer occurs when req_valid[w] & req_ready[w] are both high.
  - On transfer: capture req_data into wr_data, set owner=w, go to ISSUE.
- IDLE, lock update on transfer:
  - req_last[w]=0: locked=1.
  - req_last[w]=1: locked=0 and rr_ptr=(w+1) mod NUM_REQ.
  - rr_ptr is unchanged while locked.
- Locked with req_valid[owner]=0: the arbiter idles. Other requesters are not served and there is no lock timeout.
- ISSUE: wr_en=1 for exactly one cycle, then WAIT_BUSY. Latency from transfer cycle to wr_en is 1 cycle.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, set timeout_err=1 and go to IDLE (byte considered lost).
  - The counter clears on entry to WAIT_BUSY.
- WAIT_DONE: stay while tx_busy=1. When tx_busy=0, go to IDLE; a new grant is possible that same cycle, since req_ready in IDLE depends on the current tx_busy.
- Throughput: at most one byte per uart_top frame. Minimum 4 cycles between wr_en strobes.
- tx_busy=1 while in IDLE (external use): no grant until it clears.
- Simultaneous valid on all requesters, unlocked, single-byte packets: grant order follows rr_ptr, e.g. rr_ptr=2 gives 2,3,0,1.
- req_data/req_last are only sampled in the transfer cycle. A requester deasserting req_valid before ready has no effect.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). A byte already inside uart_top is not tracked or retried.
- timeout_err clears only by reset.

Decomposition:
- Shared package: FSM state encoding (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE), the ARB_IDX_W=clog2(NUM_REQ) helper, and the BUSY_TIMEOUT default.
- Sub-module rr_pick: a combinational round-robin priority picker taking request mask and pointer, returning grant index and grant-valid. The top module holds the FSM, lock, pointer and timeout counter.

Test Plan:
- Single request: req_valid[1]=1, data 0xA5, last=1 -> req_ready[1] pulses once; wr_en one cycle later with wr_data=0xA5; locked stays 0; rr_ptr becomes 2; loopback uart_top rx_data=0xA5.
- Fairness: all four requesters valid, single-byte packets, rr_ptr=0 -> wr_data sequence from requesters 0,1,2,3,0...; no requester is granted twice before the others are served.
- Packet lock: requester 2 sends 3 bytes (last on the third) while requester 0 stays valid -> all three req2 bytes go out consecutively; locked is 1 after bytes 1 and 2; req0 is granted next.
- Locked stall: requester 3 sends a byte with last=0, then drops req_valid for 50 cycles while requester 1 is valid -> no wr_en for those 50 cycles; req3 resumes and sends its last byte, then req1 is granted.
- Timeout: stub tx_busy held at 0 -> timeout_err=1 exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry; FSM returns to IDLE and the next grant proceeds; timeout_err stays 1.
- Reset mid-frame: assert rstb low during WAIT_DONE -> all outputs at reset values immediately; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter slice:
//   - arb_state_t : transmit sequencing FSM encoding
//   - arb_idx_w() : width of a requester index (clog2, minimum 1)
//   - BUSY_TIMEOUT_DEF : default cycles to wait for tx_busy to rise
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int BUSY_TIMEOUT_DEF = 4;

  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick
//   Combinational round-robin priority picker. Scans the request mask
//   upward starting at ptr, wrapping NUM_REQ-1 -> 0, and returns the first
//   set position.
// Ports:
//   req      in  [NUM_REQ-1:0]  candidate mask
//   ptr      in  [IDX_W-1:0]    highest-priority position this cycle
//   gnt_idx  out [IDX_W-1:0]    winning index (0 when none)
//   gnt_vld  out                at least one candidate present
module uart_tx_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the uart_top transmit path among NUM_REQ byte sources.
//   Round-robin arbitration; a packet (bytes up to and including req_last)
//   locks the grant to its owner so packets never interleave. Each byte is
//   issued with a one-cycle wr_en, then the FSM waits for tx_busy to rise
//   and fall before the next grant.
// Ports:
//   clk          in   system clock
//   rstb         in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ-1:0]   per-requester byte available
//   req_data     in   [8*NUM_REQ-1:0] requester i at bits [8i+7:8i]
//   req_last     in   [NUM_REQ-1:0]   byte ends its packet
//   req_ready    out  [NUM_REQ-1:0]   combinational accept for the winner
//   wr_en        out  one-cycle write strobe to uart_top
//   wr_data      out  [7:0] byte to uart_top, stable until back in IDLE
//   tx_busy      in   uart_top transmitter busy
//   owner        out  index of the last granted requester
//   locked       out  packet in progress, only owner may be granted
//   timeout_err  out  sticky: tx_busy did not rise within BUSY_TIMEOUT
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  localparam int IDX_W        = arb_idx_w(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   wr_en,
  output logic [7:0]             wr_data,
  input  logic                   tx_busy,
  output logic [IDX_W-1:0]       owner,
  output logic                   locked,
  output logic                   timeout_err
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner_q;
  logic             locked_q;
  logic [7:0]       wr_data_q;
  logic [3:0]       busy_cnt;
  logic             err_q;

  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               grant_ok;
  logic               xfer;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               sel_valid;
  logic [3:0]         cnt_inc;
  logic               timeout_hit;
  logic [IDX_W-1:0]   ptr_nxt;

  // While a packet is open only the owner is eligible, even if it has
  // nothing to send: the arbiter then simply idles.
  always_comb begin
    cand = '0;
    if (locked_q) begin
      for (int i = 0; i < NUM_REQ; i++)
        cand[i] = (owner_q == IDX_W'(i));
    end else begin
      cand = req_valid;
    end
  end

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (cand),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Winner's lane, selected by compare rather than a variable part-select.
  always_comb begin
    sel_data  = 8'h00;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_data  = req_data[8*i +: 8];
        sel_last  = req_last[i];
        sel_valid = req_valid[i];
      end
    end
  end

  // tx_busy is looked at live so a grant can follow WAIT_DONE->IDLE
  // immediately, and an externally busy transmitter blocks grants in IDLE.
  always_comb begin
    grant_ok  = (state == IDLE) && !tx_busy && gnt_vld;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = grant_ok && (gnt_idx == IDX_W'(i));
    xfer = grant_ok && sel_valid;
  end

  assign cnt_inc     = busy_cnt + 4'd1;
  assign timeout_hit = (cnt_inc == 4'(BUSY_TIMEOUT));
  assign ptr_nxt     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (xfer) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)          state_nxt = WAIT_DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner_q   <= '0;
      locked_q  <= 1'b0;
      wr_data_q <= 8'h00;
      busy_cnt  <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        wr_data_q <= sel_data;
        owner_q   <= gnt_idx;
        if (sel_last) begin
          locked_q <= 1'b0;
          rr_ptr   <= ptr_nxt;
        end else begin
          locked_q <= 1'b1;
        end
      end
      // ISSUE always precedes WAIT_BUSY, so clearing here clears on entry.
      if (state == ISSUE) begin
        busy_cnt <= 4'd0;
      end else if (state == WAIT_BUSY && !tx_busy) begin
        busy_cnt <= cnt_inc;
        if (timeout_hit) err_q <= 1'b1;
      end
    end
  end

  assign wr_en       = (state == ISSUE);
  assign wr_data     = wr_data_q;
  assign owner       = owner_q;
  assign locked      = locked_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int BTO  = 4;

  logic            clk = 1'b0;
  logic            rstb;
  logic [NREQ-1:0] req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic            wr_en;
  logic [7:0]      wr_data;
  logic            tx_busy;
  logic [1:0]      owner;
  logic            locked;
  logic            timeout_err;

  logic busy_stub, busy_ext, busy_resp;
  int   busy_len;
  assign tx_busy = busy_stub | busy_ext;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(BTO)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_busy     (tx_busy),
    .owner       (owner),
    .locked      (locked),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Per-requester byte queues: {last, data}
  logic [8:0] q0[$], q1[$], q2[$], q3[$];

  task automatic push_req(input int i, input logic last, input logic [7:0] d);
    case (i)
      0: q0.push_back({last, d});
      1: q1.push_back({last, d});
      2: q2.push_back({last, d});
      default: q3.push_back({last, d});
    endcase
  endtask

  function automatic logic [9:0] head(input int i);
    case (i)
      0: return (q0.size() > 0) ? {1'b1, q0[0]} : 10'h0;
      1: return (q1.size() > 0) ? {1'b1, q1[0]} : 10'h0;
      2: return (q2.size() > 0) ? {1'b1, q2[0]} : 10'h0;
      default: return (q3.size() > 0) ? {1'b1, q3[0]} : 10'h0;
    endcase
  endfunction

  task automatic pop_req(input int i);
    case (i)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: handshake seen at negedge, next byte presented after the edge.
  initial begin
    logic [NREQ-1:0] hs;
    logic [9:0] h;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) pop_req(i);
        h = head(i);
        req_valid[i]       = h[9];
        req_last[i]        = h[8];
        req_data[8*i +: 8] = h[7:0];
      end
    end
  end

  // uart_top stub: busy rises the cycle after wr_en and holds busy_len edges.
  initial begin
    busy_stub = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_en && busy_resp) begin
        @(posedge clk); #1;
        busy_stub = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        busy_stub = 1'b0;
      end
    end
  end

  logic [7:0] wlog[$];
  logic       lk_log[$];
  int wr_cyc = 0, hs_cyc = 0, err_cyc = 0, r1cnt = 0;
  logic err_seen = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      wlog.push_back(wr_data);
      lk_log.push_back(locked);
      wr_cyc = cyc;
    end
    if (|(req_valid & req_ready)) hs_cyc = cyc;
    if (req_ready[1]) r1cnt++;
    if (timeout_err && !err_seen) begin
      err_seen = 1'b1;
      err_cyc  = cyc;
    end
  end

  function automatic logic [7:0] log_at(input int i);
    return (wlog.size() > i) ? wlog[i] : 8'hxx;
  endfunction

  function automatic logic lk_at(input int i);
    return (lk_log.size() > i) ? lk_log[i] : 1'bx;
  endfunction

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && wlog.size() < n; i++) begin
      @(negedge clk); #1;
    end
    chk("wait_bytes", wlog.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    #2 rstb = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int stall_sz;
    logic [7:0] exp_fair [8];
    rstb = 1'b0; busy_ext = 1'b0; busy_resp = 1'b1; busy_len = 3;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout_err, 0);
    #2 rstb = 1'b1;

    // Single request from requester 1
    r1cnt = 0;
    push_req(1, 1'b1, 8'hA5);
    wait_bytes(1, 50);
    chk("single_latency", wr_cyc - hs_cyc, 1);
    repeat (10) @(negedge clk);
    chk("single_data", log_at(0), 8'hA5);
    chk("single_ready_pulses", r1cnt, 1);
    chk("single_locked", locked, 0);
    chk("single_owner", owner, 1);

    // rr_ptr now 2: all four valid -> 2,3,0,1
    base = wlog.size();
    for (int i = 0; i < NREQ; i++) push_req(i, 1'b1, 8'h10 + 8'(i));
    wait_bytes(base + 4, 200);
    chk("ptr2_b0", log_at(base + 0), 8'h12);
    chk("ptr2_b1", log_at(base + 1), 8'h13);
    chk("ptr2_b2", log_at(base + 2), 8'h10);
    chk("ptr2_b3", log_at(base + 3), 8'h11);

    // Fairness from rr_ptr=0 after reset
    do_reset();
    base = wlog.size();
    for (int i = 0; i < NREQ; i++) push_req(i, 1'b1, 8'h20 + 8'(i));
    for (int i = 0; i < NREQ; i++) push_req(i, 1'b1, 8'h28 + 8'(i));
    exp_fair = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h28, 8'h29, 8'h2A, 8'h2B};
    wait_bytes(base + 8, 400);
    for (int i = 0; i < 8; i++) chk($sformatf("fair_b%0d", i), log_at(base + i), exp_fair[i]);

    // Packet lock: req2 three-byte packet while req0 waits (rr_ptr=0)
    base = wlog.size();
    push_req(2, 1'b0, 8'h41);
    push_req(2, 1'b0, 8'h42);
    push_req(2, 1'b1, 8'h43);
    wait_bytes(base + 1, 50);
    push_req(0, 1'b1, 8'h05);
    wait_bytes(base + 4, 200);
    chk("lock_b0", log_at(base + 0), 8'h41);
    chk("lock_b1", log_at(base + 1), 8'h42);
    chk("lock_b2", log_at(base + 2), 8'h43);
    chk("lock_b3", log_at(base + 3), 8'h05);
    chk("lock_lk0", lk_at(base + 0), 1);
    chk("lock_lk1", lk_at(base + 1), 1);
    chk("lock_lk2", lk_at(base + 2), 0);

    // Locked stall: req3 opens a packet and goes quiet (rr_ptr=1)
    base = wlog.size();
    push_req(3, 1'b0, 8'h31);
    wait_bytes(base + 1, 50);
    push_req(1, 1'b1, 8'h11);
    stall_sz = wlog.size();
    repeat (50) @(negedge clk);
    chk("stall_no_wr", wlog.size(), stall_sz);
    chk("stall_locked", locked, 1);
    chk("stall_owner", owner, 3);
    push_req(3, 1'b1, 8'h32);
    wait_bytes(base + 3, 200);
    chk("stall_b1", log_at(base + 1), 8'h32);
    chk("stall_b2", log_at(base + 2), 8'h11);

    // Timeout: stub never raises tx_busy (rr_ptr=2)
    busy_resp = 1'b0;
    base = wlog.size();
    push_req(2, 1'b1, 8'h55);
    wait_bytes(base + 1, 50);
    for (int i = 0; i < 30 && !err_seen; i++) begin
      @(negedge clk); #1;
    end
    chk("to_err", timeout_err, 1);
    chk("to_delay", err_cyc - wr_cyc, BTO + 1);
    busy_resp = 1'b1;
    push_req(3, 1'b1, 8'h66);
    wait_bytes(base + 2, 100);
    chk("to_next", log_at(base + 1), 8'h66);
    chk("to_sticky", timeout_err, 1);

    // External busy in IDLE blocks grants
    repeat (10) @(negedge clk);
    busy_ext = 1'b1;
    base = wlog.size();
    push_req(0, 1'b1, 8'h77);
    repeat (10) @(negedge clk);
    chk("ext_busy_ready", req_ready, 0);
    chk("ext_busy_no_wr", wlog.size(), base);
    busy_ext = 1'b0;
    wait_bytes(base + 1, 50);
    chk("ext_busy_b0", log_at(base), 8'h77);

    // Reset during WAIT_DONE (rr_ptr=1 -> 2 after this grant)
    repeat (10) @(negedge clk);
    busy_len = 6;
    base = wlog.size();
    push_req(1, 1'b1, 8'h88);
    wait_bytes(base + 1, 50);
    @(negedge clk);
    @(negedge clk);
    #1 rstb = 1'b0;
    #1;
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    #2 rstb = 1'b1;
    push_req(3, 1'b1, 8'h93);
    push_req(0, 1'b1, 8'h90);
    wait_bytes(base + 3, 200);
    chk("post_rst_b0", log_at(base + 1), 8'h90);
    chk("post_rst_b1", log_at(base + 2), 8'h93);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
